bus_uart_tx: RTL and testbench
==============================

// Module: bus_uart_tx
// PURPOSE
//   Memory-mapped UART transmitter: a slave on the CPU memory bus, downstream of the core.
//   Accepts byte writes from the core into a FIFO and serialises them 8N1 on a TX pin.
//   Raises a level interrupt toward the core's irq input when transmission drains.
// PARAMETERS
//   CLK_FREQ_HZ  24_000_000  system clock frequency
//   BAUD_RATE    115_200     line rate; DIVIDER = CLK_FREQ_HZ / BAUD_RATE (floor), must be >= 2
//   FIFO_DEPTH   8           TX FIFO entries; power of two, >= 2
// PORTS
//   clk      in   1   system clock
//   reset    in   1   asynchronous, active-high reset
//   valid    in   1   bus request from master (this slave is already selected)
//   address  in   32  byte address; only address[3:2] decoded
//   wstrobe  in   4   byte write enables; all zero = read
//   wdata    in   32  write data
//   rdata    out  32  read data, valid while ready=1
//   ready    out  1   one-cycle transfer acknowledge
//   irq      out  1   level interrupt request
//   tx       out  1   serial output, idle high
// BEHAVIOUR
//   Reset (async): tx=1, ready=0, rdata=0, irq=0, FIFO empty, irq_en=0, overflow=0, FSM IDLE.
//   Handshake: ready <= valid && !ready (registered). Transfer completes in the cycle
//     valid && ready; all side effects happen in that cycle only. Latency 1 wait cycle;
//     back-to-back requests alternate ready 0/1. Valid dropped while ready=0: no effect.
//   Register map (address[3:2]):
//     0 DATA   W: if wstrobe[0], push wdata[7:0]. R: 0.
//     1 STATUS R: [0]=fifo_empty [1]=fifo_full [2]=busy (FSM != IDLE) [3]=overflow
//              [7:4]=fifo count (saturates display at 15); others 0.
//              W: if wstrobe[0] && wdata[3], clear overflow.
//     2 CTRL   R/W: [0]=irq_en (written when wstrobe[0]); others read 0.
//     3 -      R: 0; W: ignored.
//   rdata registered alongside ready; rdata=0 whenever ready=0.
//   FIFO: push when full and no pop in the same cycle -> byte dropped, overflow set (sticky).
//     Push and pop in the same cycle: both take effect (also when full); count unchanged.
//     Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//   Transmit FSM, baud counter counts DIVIDER-1 down to 0 per bit:
//     IDLE : tx=1; if FIFO non-empty, pop into shift reg, load counter -> START.
//     START: tx=0 for DIVIDER cycles -> DATA.
//     DATA : tx=shift[0], LSB first; 8 bits, each DIVIDER cycles -> STOP.
//     STOP : tx=1 for DIVIDER cycles -> IDLE.
//     Frame = 10*DIVIDER cycles; with FIFO non-empty, IDLE lasts exactly 1 cycle between frames.
//   irq = irq_en && fifo_empty && FSM==IDLE (combinational from registers, no glitch on reset).
//   Reset mid-frame: tx returns to 1 immediately, frame and FIFO contents discarded.
// TESTING (bench uses CLK_FREQ_HZ=400, BAUD_RATE=100 -> DIVIDER=4, FIFO_DEPTH=4)
//   Write DATA=0x55, wstrobe=0001 -> ready one cycle later; tx: 0 x4, then 1,0,1,0,1,0,1,0
//     each x4, then 1 x4; STATUS.busy=1 during frame, 0 after; total frame 40 cycles.
//   Hold valid high on READ STATUS for 6 cycles -> ready pattern 0,1,0,1,0,1; rdata=0x01
//     only in ready cycles, 0 otherwise.
//   Write 6 bytes 0xA0..0xA5 back-to-back while first frame starts -> first pops, 4 stored,
//     last dropped; STATUS.overflow=1, full=1; write STATUS wdata=0x8 -> overflow=0;
//     serial output shows 0xA0..0xA4 in order, 1 idle cycle between frames.
//   CTRL=1 with FIFO empty, IDLE -> irq=1; write DATA=0x00 -> irq=0 from next cycle
//     until 40 cycles after pop plus return to IDLE, then irq=1; CTRL=0 -> irq=0.
//   Assert reset asynchronously mid-DATA of 0x0F with 2 bytes queued -> tx=1, ready=0,
//     STATUS=0x01 after release, no further frames emitted.
//   Write DATA with wstrobe=0000 and to address offset 0xC -> no push, count stays 0,
//     ready still pulses once.

Source files
------------

// File: rtl/bus_uart_tx.sv
// -----------------------------------------------------------------------------
// bus_uart_tx
//   Memory-mapped 8N1 UART transmitter sitting on the CPU memory bus. The core
//   writes bytes into a small TX FIFO; a bit-serial engine drains the FIFO onto
//   the tx pin, LSB first, one start and one stop bit per byte. A level
//   interrupt is raised when the engine is idle with nothing left to send.
//
// Ports
//   clk      in   1   system clock
//   reset    in   1   asynchronous, active-high reset
//   valid    in   1   bus request (slave already selected)
//   address  in   32  byte address, only address[3:2] decoded
//   wstrobe  in   4   byte write enables, all zero means read
//   wdata    in   32  write data
//   rdata    out  32  read data, meaningful only while ready=1, else 0
//   ready    out  1   single-cycle transfer acknowledge
//   irq      out  1   level interrupt: irq_en && fifo empty && engine idle
//   tx       out  1   serial line, idle high
//
// Register map (address[3:2])
//   0 DATA    W: wstrobe[0] pushes wdata[7:0]            R: 0
//   1 STATUS  R: [0] empty [1] full [2] busy [3] overflow [7:4] count (sat 15)
//             W: wstrobe[0] && wdata[3] clears overflow
//   2 CTRL    R/W: [0] irq_en
//   3 -       R: 0, W: ignored
// -----------------------------------------------------------------------------
module bus_uart_tx #(
    parameter int CLK_FREQ_HZ = 24_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] address,
    input  logic [3:0]  wstrobe,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        irq,
    output logic        tx
);

    localparam int DIVIDER = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;

    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(DIVIDER - 1);
    localparam logic [CW-1:0]    DEPTH_C     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // The count field is only four bits wide, so deeper FIFOs show 15.
    function automatic logic [3:0] sat_count(input logic [CW-1:0] c);
        if (int'(c) > 15) return 4'hF;
        return 4'(c);
    endfunction

    // Bus side
    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_irq_en;

    // FIFO
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    // Serialiser
    state_t          r_state;
    logic [CNT_W-1:0] r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;

    logic             w_xfer;
    logic [1:0]       w_addr;
    logic             w_push;
    logic             w_push_ok;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic             w_busy;
    logic             w_ovf_clr;
    logic [7:0]       w_status;
    logic [31:0]      w_rd_mux;
    state_t           w_state_nx;
    logic [CNT_W-1:0] w_baud_nx;
    logic [2:0]       w_bit_nx;
    logic [7:0]       w_shift_nx;
    logic             w_tx;
    logic             w_unused;

    assign w_unused = ^{address[31:4], address[1:0], wstrobe[3:1], wdata[31:8]};

    // ---- bus decode: side effects only in the valid && ready cycle ----
    assign w_xfer    = valid && r_ready;
    assign w_addr    = address[3:2];
    assign w_push    = w_xfer && (w_addr == 2'd0) && wstrobe[0];
    assign w_ovf_clr = w_xfer && (w_addr == 2'd1) && wstrobe[0] && wdata[3];

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);
    assign w_busy  = (r_state != S_IDLE);

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push_ok = w_push && (!w_full || w_pop);

    assign w_status = {sat_count(r_count), r_overflow, w_busy, w_full, w_empty};

    always_comb begin
        w_rd_mux = '0;
        case (w_addr)
            2'd1:    w_rd_mux = {24'b0, w_status};
            2'd2:    w_rd_mux = {31'b0, r_irq_en};
            default: w_rd_mux = '0;
        endcase
    end

    // rdata is captured together with ready, so it reflects register state
    // one cycle before the acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_irq_en <= 1'b0;
        end else begin
            r_ready <= valid && !r_ready;
            r_rdata <= (valid && !r_ready) ? w_rd_mux : '0;
            if (w_xfer && (w_addr == 2'd2) && wstrobe[0]) begin
                r_irq_en <= wdata[0];
            end
        end
    end

    // ---- FIFO ----
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop)     r_rptr <= r_rptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ---- serialiser: every bit period is DIVIDER cycles, counter runs DIVIDER-1..0 ----
    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_pop      = 1'b0;
        w_tx       = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = r_mem[r_rptr];
                    w_baud_nx  = BAUD_RELOAD;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (r_baud == '0) begin
                    w_baud_nx  = BAUD_RELOAD;
                    w_bit_nx   = 3'd0;
                    w_state_nx = S_DATA;
                end else begin
                    w_baud_nx = r_baud - CNT_W'(1);
                end
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (r_baud == '0) begin
                    w_baud_nx  = BAUD_RELOAD;
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nx = S_STOP;
                    end else begin
                        w_bit_nx = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nx = r_baud - CNT_W'(1);
                end
            end
            S_STOP: begin
                w_tx = 1'b1;
                if (r_baud == '0) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_baud_nx = r_baud - CNT_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nx;
    end

    // tx and irq decode registered state only, so reset forces them at once.
    assign tx    = w_tx;
    assign irq   = r_irq_en && w_empty && (r_state == S_IDLE);
    assign ready = r_ready;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_bus_uart_tx.sv
module tb_bus_uart_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] address = '0;
    logic [3:0]  wstrobe = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;
    logic        tx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_starts = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    logic [39:0] mon_smp;
    logic [39:0] mon_pat;
    logic [7:0]  mon_exp;
    logic [7:0]  mon_got;
    bit          mon_abort;

    bus_uart_tx #(
        .CLK_FREQ_HZ(400),
        .BAUD_RATE  (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .valid  (valid),
        .address(address),
        .wstrobe(wstrobe),
        .wdata  (wdata),
        .rdata  (rdata),
        .ready  (ready),
        .irq    (irq),
        .tx     (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Serial line monitor: captures 40 samples per frame and compares to the scoreboard.
    always begin
        @(negedge clk);
        if (!reset && tx === 1'b0) begin
            start_q.push_back(cyc);
            n_starts++;
            mon_smp   = '0;
            mon_abort = 1'b0;
            for (int c = 1; c < 40; c++) begin
                @(negedge clk);
                if (reset) begin
                    mon_abort = 1'b1;
                    break;
                end
                mon_smp[c] = tx;
            end
            if (!mon_abort) begin
                for (int b = 0; b < 8; b++) mon_got[b] = mon_smp[4 + 4*b + 1];
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_unexpected got byte %h pattern %b", mon_got, mon_smp);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_pat = '0;
                    for (int b = 0; b < 8; b++) mon_pat[4 + 4*b +: 4] = {4{mon_exp[b]}};
                    mon_pat[39:36] = 4'hF;
                    if (mon_smp !== mon_pat) begin
                        errors++;
                        $display("FAIL frame got %b (byte %h) exp %b (byte %h)",
                                 mon_smp, mon_got, mon_pat, mon_exp);
                    end
                end
            end
        end
    end

    task automatic bus_op(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                          input bit keep, output logic [31:0] rd, output int lat,
                          output logic rdy_after);
        valid   = 1'b1;
        address = a;
        wstrobe = ws;
        wdata   = wd;
        lat     = 0;
        rd      = '0;
        rdy_after = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) begin
                lat = i;
                rd  = rdata;
                break;
            end
        end
        if (lat == 0) begin
            valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rdy_after = ready;
        if (!keep) valid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        logic ra;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        checks++; if (irq !== 1'b0)   begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        bus_op(32'h4, 4'h0, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (rd !== 32'h01) begin errors++; $display("FAIL reset_status got %h exp 00000001", rd); end
        checks++; if (lat !== 1)     begin errors++; $display("FAIL reset_latency got %0d exp 1", lat); end
        bus_op(32'h8, 4'h0, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (rd !== 32'h0)  begin errors++; $display("FAIL reset_ctrl got %h exp 0", rd); end
    endtask

    task automatic test_tx_55();
        logic [31:0] rd;
        int lat;
        logic ra;
        bit ok;
        exp_q.push_back(8'h55);
        bus_op(32'h0, 4'h1, 32'h55, 1'b0, rd, lat, ra);
        checks++; if (lat !== 1)   begin errors++; $display("FAIL tx55_latency got %0d exp 1", lat); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL tx55_ready_single got %b exp 0", ra); end
        repeat (3) @(posedge clk);
        #1;
        bus_op(32'h4, 4'h0, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (rd !== 32'h05) begin errors++; $display("FAIL tx55_status_busy got %h exp 00000005", rd); end
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL tx55_drain got timeout exp frame"); end
        bus_op(32'h4, 4'h0, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (rd !== 32'h01) begin errors++; $display("FAIL tx55_status_idle got %h exp 00000001", rd); end
    endtask

    task automatic test_read_hold();
        logic exp_r;
        address = 32'h4;
        wstrobe = 4'h0;
        wdata   = 32'h0;
        valid   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) begin
                @(posedge clk);
                #1;
            end
            exp_r = (i % 2 == 1);
            checks++;
            if (ready !== exp_r) begin
                errors++; $display("FAIL hold_ready[%0d] got %b exp %b", i, ready, exp_r);
            end
            checks++;
            if (rdata !== (exp_r ? 32'h1 : 32'h0)) begin
                errors++; $display("FAIL hold_rdata[%0d] got %h exp %h", i, rdata, exp_r ? 32'h1 : 32'h0);
            end
        end
        valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        int lat;
        logic ra;
        bit ok;
        start_q.delete();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(8'(8'hA0 + i));
            bus_op(32'h0, 4'h1, 32'(32'hA0 + i), (i < 5), rd, lat, ra);
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL b2b_latency[%0d] got %0d exp 1", i, lat); end
        end
        bus_op(32'h4, 4'h0, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (rd !== 32'h4E) begin errors++; $display("FAIL ovf_status got %h exp 0000004e", rd); end
        bus_op(32'h4, 4'h1, 32'h8, 1'b0, rd, lat, ra);
        bus_op(32'h4, 4'h0, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (rd !== 32'h46) begin errors++; $display("FAIL ovf_clear got %h exp 00000046", rd); end
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_drain got timeout exp 5 frames"); end
        checks++;
        if (start_q.size() !== 5) begin
            errors++; $display("FAIL ovf_frame_count got %0d exp 5", start_q.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (start_q[i] - start_q[i-1] !== 41) begin
                    errors++; $display("FAIL frame_gap[%0d] got %0d exp 41", i, start_q[i] - start_q[i-1]);
                end
            end
        end
        bus_op(32'h4, 4'h0, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (rd !== 32'h01) begin errors++; $display("FAIL ovf_status_end got %h exp 00000001", rd); end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        int lat;
        logic ra;
        int k_found;
        bus_op(32'h8, 4'h1, 32'h1, 1'b0, rd, lat, ra);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_enable got %b exp 1", irq); end
        bus_op(32'h8, 4'h0, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL irq_ctrl_read got %h exp 00000001", rd); end
        exp_q.push_back(8'h00);
        bus_op(32'h0, 4'h1, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_push got %b exp 0", irq); end
        k_found = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (irq === 1'b1) begin
                k_found = k;
                break;
            end
        end
        checks++; if (k_found !== 41) begin errors++; $display("FAIL irq_return got %0d exp 41", k_found); end
        bus_op(32'h8, 4'h1, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disable got %b exp 0", irq); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat;
        logic ra;
        int n1;
        exp_q.push_back(8'h0F);
        bus_op(32'h0, 4'h1, 32'h0F, 1'b0, rd, lat, ra);
        bus_op(32'h0, 4'h1, 32'h11, 1'b0, rd, lat, ra);
        bus_op(32'h0, 4'h1, 32'h22, 1'b0, rd, lat, ra);
        repeat (18) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_pre_tx got %b exp 0", tx); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL rstmid_tx got %b exp 1", tx); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b exp 0", ready); end
        checks++; if (irq !== 1'b0)   begin errors++; $display("FAIL rstmid_irq got %b exp 0", irq); end
        exp_q.delete();
        n1 = n_starts;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        bus_op(32'h4, 4'h0, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (rd !== 32'h01) begin errors++; $display("FAIL rstmid_status got %h exp 00000001", rd); end
        repeat (100) @(posedge clk);
        #1;
        checks++; if (n_starts !== n1) begin errors++; $display("FAIL rstmid_no_frames got %0d exp %0d", n_starts, n1); end
    endtask

    task automatic test_ignored();
        logic [31:0] rd;
        int lat;
        logic ra;
        int n0;
        n0 = n_starts;
        bus_op(32'h0, 4'h0, 32'h33, 1'b0, rd, lat, ra);
        checks++; if (lat !== 1)   begin errors++; $display("FAIL ign_nostrobe_lat got %0d exp 1", lat); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL ign_nostrobe_ready got %b exp 0", ra); end
        bus_op(32'h4, 4'h0, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (rd !== 32'h01) begin errors++; $display("FAIL ign_nostrobe_status got %h exp 00000001", rd); end
        bus_op(32'hC, 4'h1, 32'h77, 1'b0, rd, lat, ra);
        checks++; if (lat !== 1)   begin errors++; $display("FAIL ign_addr3_lat got %0d exp 1", lat); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL ign_addr3_ready got %b exp 0", ra); end
        bus_op(32'h4, 4'h0, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (rd !== 32'h01) begin errors++; $display("FAIL ign_addr3_status got %h exp 00000001", rd); end
        bus_op(32'hC, 4'h0, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (rd !== 32'h0)  begin errors++; $display("FAIL ign_addr3_read got %h exp 0", rd); end
        bus_op(32'h0, 4'h0, 32'h0, 1'b0, rd, lat, ra);
        checks++; if (rd !== 32'h0)  begin errors++; $display("FAIL ign_data_read got %h exp 0", rd); end
        repeat (10) @(posedge clk);
        #1;
        checks++; if (n_starts !== n0) begin errors++; $display("FAIL ign_no_frames got %0d exp %0d", n_starts, n0); end
    endtask

    initial begin
        test_reset();
        test_tx_55();
        test_read_hold();
        test_overflow();
        test_irq();
        test_reset_mid();
        test_ignored();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
